// File: rtl/switch_debounce_controller.sv
// Avalon-MM input conditioner for slide switches and push-buttons.
// Each input bit is synchronized through two flops, debounced by its own
// stability counter, and its rising edges are latched in a write-1-to-clear
// capture register that drives a maskable level interrupt.
module switch_debounce_controller #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // Zero-extend a WIDTH-bit register image onto the 32-bit data bus.
    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r          = 32'd0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] db_q;
    logic [WIDTH-1:0] db_d;
    logic [WIDTH-1:0] db_dly_q;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] irqmask_d;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             irq_q;
    logic             irq_d;
    logic             wr_en_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] clr_s;
    logic             unused_wdata_s;

    assign wr_en_s        = chipselect & ~write_n;
    // Only the low WIDTH bits of writedata carry meaning; the rest are ignored.
    assign unused_wdata_s = ^writedata;
    assign readdata       = readdata_q;
    assign irq            = irq_q;

    // Per-bit stability counters: the debounced value follows sync2 only after
    // DEBOUNCE_CYCLES consecutive cycles of disagreement; any agreement restarts.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = CNT_ZERO;
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = CNT_ZERO;
            end else if (cnt_q[i] == CNT_MAX) begin
                db_d[i]  = sync2_q[i];
                cnt_d[i] = CNT_ZERO;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Register-file writes, edge capture (new edge beats a same-cycle clear),
    // interrupt level and the always-registered read mux.
    always_comb begin
        irqmask_d = irqmask_q;
        clr_s     = {WIDTH{1'b0}};
        if (wr_en_s) begin
            case (address)
                2'd1:    irqmask_d = writedata[WIDTH-1:0];
                2'd2:    clr_s     = writedata[WIDTH-1:0];
                default: clr_s     = {WIDTH{1'b0}};
            endcase
        end else begin
            irqmask_d = irqmask_q;
            clr_s     = {WIDTH{1'b0}};
        end

        rise_s = db_q & ~db_dly_q;
        edge_d = (edge_q & ~clr_s) | rise_s;
        irq_d  = |(edge_q & irqmask_q);

        case (address)
            2'd0:    readdata_d = zext(db_q);
            2'd1:    readdata_d = zext(irqmask_q);
            2'd2:    readdata_d = zext(edge_q);
            2'd3:    readdata_d = zext(sync2_q);
            default: readdata_d = 32'd0;
        endcase
    end

    // State update with synchronous reset; reset also discards partial counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= {WIDTH{1'b0}};
            sync2_q    <= {WIDTH{1'b0}};
            db_q       <= {WIDTH{1'b0}};
            db_dly_q   <= {WIDTH{1'b0}};
            irqmask_q  <= {WIDTH{1'b0}};
            edge_q     <= {WIDTH{1'b0}};
            readdata_q <= 32'd0;
            irq_q      <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            db_q       <= db_d;
            db_dly_q   <= db_q;
            irqmask_q  <= irqmask_d;
            edge_q     <= edge_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: doc/switch_debounce_controller.md
Name: switch_debounce_controller

Overview:
Avalon-MM slave controller that conditions the board's slide switches and push-buttons before software sees them. Per bit, it synchronizes, debounces with a per-bit stability counter, and captures rising edges. It also raises a maskable interrupt so the Nios II alarm-clock firmware can react to button presses without polling. It sits between the raw FPGA pins and the system interconnect, in the same slot as a plain input PIO.

Parameters:
WIDTH, 4, number of switch/button inputs (1..32)
DEBOUNCE_CYCLES, 50000, clk cycles a synchronized input must stay stable before the debounced value follows (>=1; 1 ms at 50 MHz)
CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
address  input  2  Avalon word address
chipselect  input  1  Avalon slave select
write_n  input  1  active-low write strobe, qualified by chipselect
writedata  input  32  write data
readdata  output  32  registered read data
in_port  input  WIDTH  raw asynchronous switch/button pins
irq  output  1  level interrupt, active-high

Behaviour:
- Reset: synchronous, active-high, sampled on clk rising edge. Clears the synchronizer flops, debounce counters, debounced value, irqmask, edgecapture, readdata and irq to 0. This also applies mid-debounce: a partially counted bit is discarded and restarts from 0.
- Synchronizer: 2-flop chain per bit, sync1 <= in_port, sync2 <= sync1. No other logic reads in_port directly.
- Debounce, per bit i, with debounced register db[i] and counter cnt[i]:
  - If sync2[i] == db[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: db[i] <= sync2[i], cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - Any glitch shorter than DEBOUNCE_CYCLES consecutive cycles at sync2 is rejected (the counter restarts).
  - Latency: if in_port changes before edge k and then stays stable, sync2 holds the new value after edge k+1 and db updates at edge k+1+DEBOUNCE_CYCLES.
  - Bits are fully independent; no shared counter.
- Edge capture: a rising edge on bit i is db[i] going 0->1, detected in the cycle db updates. It sets edgecapture[i] on the following edge. Falling edges are not captured.
- Register map (word addresses; unused upper bits read 0, writes to them ignored):
  - 0 DATA: db[WIDTH-1:0], read-only; writes ignored.
  - 1 IRQMASK: RW, WIDTH bits.
  - 2 EDGECAPTURE: read returns edgecapture. Write: each writedata bit = 1 clears the corresponding edgecapture bit (write-1-to-clear).
  - 3 RAW: sync2[WIDTH-1:0], read-only; for diagnostics.
- Write: accepted when chipselect=1 and write_n=0; takes effect at that clk edge. No wait states.
- Read: readdata is registered every cycle from the address mux, as a plain PIO does; no read strobe is required. readdata reflects the register contents one cycle after address is presented, so read latency is 1.
- Simultaneous events:
  - An EDGECAPTURE clear and a new edge on the same bit in the same cycle: the edge wins and the bit stays 1.
  - A clear of a bit with no new edge clears it.
  - An IRQMASK write and an edge in the same cycle: the new mask is used from the next cycle on.
- irq: registered, irq <= |(edgecapture & irqmask), so it lags edgecapture by 1 cycle. It stays high until software clears all masked set bits or masks them.

Test Plan:
(Tests 1-5 use WIDTH=4, DEBOUNCE_CYCLES=4.)
1. Reset: hold reset=1 for 2 cycles with in_port=4'hF -> readdata=0, irq=0. After release with in_port still 4'hF, read addr 0 -> 4'hF appears no earlier than 2+4 cycles after release.
2. Glitch reject: in_port[0] pulses high for 3 cycles and then returns low -> DATA stays 0, EDGECAPTURE stays 0, irq=0. A 6-cycle pulse -> DATA bit0=1 at the predicted edge, and EDGECAPTURE=4'h1 one cycle later.
3. Interrupt: IRQMASK=4'h2, and bit1 then bit3 rise stably -> EDGECAPTURE=4'hA and irq=1 only after bit1. Write 4'h2 to addr 2 -> EDGECAPTURE=4'h8, irq drops to 0 one cycle later.
4. Clear/edge collision: time a W1C of 4'h4 to addr 2 in the same cycle bit2's db rises -> EDGECAPTURE bit2 stays 1.
5. Falling edges and RAW: bit0 falls after being high -> EDGECAPTURE unchanged. Read addr 3 -> shows sync2 immediately after 2 cycles, before debounce completes.
6. Reset mid-count: assert reset at cnt=2 while an input is changing -> db=0 and the count restarts; the full DEBOUNCE_CYCLES are needed after release.
